// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
//
// Partial-sum stage that sits behind each PE multiplier. It sums one
// dot-product group, delimited by in_last, either as saturating signed
// integers or as fp16 values, and holds the result on a valid/ready port
// toward the array drain until it is taken.
//
// Parameters:
//   ACC_W  int-mode accumulator width (>= 17)
//   CNT_W  beat counter width (saturating)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mode              1 = fp16, 0 = int; latched on the first beat of a group
//   in_valid/in_ready product beat handshake
//   in_data           int16 two's complement or fp16 product
//   in_error          multiplier fp overflow/underflow flag for this beat
//   in_last           final beat of the group
//   out_valid/out_ready result handshake
//   out_data          int: signed sum; fp: {zeros, fp16 sum}
//   out_error         sticky error for the group
//   out_count         number of accepted beats in the group, saturating
// -----------------------------------------------------------------------------
module psum_accumulator #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_error,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_error,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [ACC_W-1:0] INT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] INT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             fpMode_q, fpMode_d;

    logic             accept;
    logic             beatMode;
    logic [ACC_W-1:0] base;

    // Integer datapath
    logic [ACC_W-1:0] beatExt;
    logic [ACC_W:0]   intWide;
    logic             intOvf;
    logic [ACC_W-1:0] intSum;

    // fp16 datapath
    logic [15:0]       fpA;
    logic [4:0]        aExp, bExp;
    logic [10:0]       aMag, bMag;
    logic              aInf, bInf;
    logic              aIsBig;
    logic              bigSign, smlSign;
    logic [4:0]        bigExp, smlExp, expDiff;
    logic [10:0]       bigMag, smlMag, smlAligned;
    logic [11:0]       rawSum;
    logic [3:0]        leadPos, shiftAmt;
    logic [9:0]        normMant;
    logic signed [6:0] expNorm;
    logic [15:0]       fpSum;
    logic              fpOvf;

    logic [ACC_W-1:0] newAcc;
    logic             newOvf;

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_data  = acc_q;
    assign out_error = err_q;
    assign out_count = count_q;

    assign accept   = in_valid && in_ready;
    // The first beat of a group takes the live mode pin; later beats use the latched one.
    assign beatMode = (state_q == IDLE) ? mode : fpMode_q;
    // IDLE always starts a fresh group from zero.
    assign base     = (state_q == IDLE) ? '0 : acc_q;

    // Saturating signed add of the sign-extended beat.
    always_comb begin
        beatExt = {{(ACC_W-16){in_data[15]}}, in_data};
        intWide = {base[ACC_W-1], base} + {beatExt[ACC_W-1], beatExt};
        intOvf  = intWide[ACC_W] ^ intWide[ACC_W-1];
        if (!intOvf) begin
            intSum = intWide[ACC_W-1:0];
        end else if (intWide[ACC_W]) begin
            intSum = INT_MIN;
        end else begin
            intSum = INT_MAX;
        end
    end

    // Single-cycle fp16 add: flush zero/subnormal, align the smaller operand
    // by truncating right shift, add/subtract magnitudes, renormalise, truncate.
    always_comb begin
        fpA  = base[15:0];
        aExp = fpA[14:10];
        bExp = in_data[14:10];
        aInf = (aExp == 5'h1F);
        bInf = (bExp == 5'h1F);
        aMag = (aExp == 5'd0) ? 11'd0 : {1'b1, fpA[9:0]};
        bMag = (bExp == 5'd0) ? 11'd0 : {1'b1, in_data[9:0]};

        aIsBig = ({aExp, aMag} >= {bExp, bMag});
        if (aIsBig) begin
            bigSign = fpA[15];    bigExp = aExp; bigMag = aMag;
            smlSign = in_data[15]; smlExp = bExp; smlMag = bMag;
        end else begin
            bigSign = in_data[15]; bigExp = bExp; bigMag = bMag;
            smlSign = fpA[15];    smlExp = aExp; smlMag = aMag;
        end

        expDiff    = bigExp - smlExp;
        smlAligned = (expDiff >= 5'd12) ? 11'd0 : (smlMag >> expDiff);

        if (bigSign == smlSign) begin
            rawSum = {1'b0, bigMag} + {1'b0, smlAligned};
        end else begin
            rawSum = {1'b0, bigMag} - {1'b0, smlAligned};
        end

        leadPos = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (rawSum[i]) begin
                leadPos = 4'(i);
            end
        end
        shiftAmt = 4'd10 - leadPos;

        if (rawSum[11]) begin
            normMant = rawSum[10:1];
            expNorm  = $signed({2'b00, bigExp}) + 7'sd1;
        end else begin
            normMant = 10'(rawSum[10:0] << shiftAmt);
            expNorm  = $signed({2'b00, bigExp}) - $signed({3'b000, shiftAmt});
        end

        fpSum = 16'h0000;
        fpOvf = 1'b0;
        if (aInf) begin
            // The accumulator already holds an inf, so it was seen first.
            fpSum = {fpA[15], 5'h1F, 10'h000};
            fpOvf = 1'b1;
        end else if (bInf) begin
            fpSum = {in_data[15], 5'h1F, 10'h000};
            fpOvf = 1'b1;
        end else if (rawSum == 12'd0) begin
            fpSum = 16'h0000;
        end else if (expNorm >= 7'sd31) begin
            fpSum = {bigSign, 5'h1F, 10'h000};
            fpOvf = 1'b1;
        end else if (expNorm <= 7'sd0) begin
            fpSum = 16'h0000;
        end else begin
            fpSum = {bigSign, expNorm[4:0], normMant};
        end

        if (beatMode) begin
            newAcc = {{(ACC_W-16){1'b0}}, fpSum};
            newOvf = fpOvf;
        end else begin
            newAcc = intSum;
            newOvf = intOvf;
        end
    end

    // Group FSM: next state and next values of accumulator, count, error, mode.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        err_d    = err_q;
        fpMode_d = fpMode_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    fpMode_d = mode;
                    acc_d    = newAcc;
                    count_d  = CNT_W'(1);
                    err_d    = in_error | newOvf;
                    state_d  = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = newAcc;
                    count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                    err_d   = err_q | in_error | newOvf;
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any partial group immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            fpMode_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            err_q    <= err_d;
            fpMode_q <= fpMode_d;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_psum_accumulator
//
// Drives psum_accumulator (ACC_W = 17, CNT_W = 4) with directed and random
// dot-product groups and compares each result against a behavioural model.
// -----------------------------------------------------------------------------
module tb_psum_accumulator;

    localparam int ACC_W = 17;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam longint INT_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint INT_MIN = -(64'sd1 <<< (ACC_W - 1));

    logic             clk;
    logic             rst;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_error;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_error;
    logic [CNT_W-1:0] out_count;

    int checkCount = 0;
    int passCount  = 0;

    logic [15:0] beatQ[$];
    logic        errQ[$];

    psum_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_error  (in_error),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_error (out_error),
        .out_count (out_count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference fp16 add from the arithmetic rules, on plain integers
    function automatic void fpAddRef(input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] r, output logic ovf);
        int ea, eb, ma, mb, eBig, eSml, mBig, mSml, d, s, e;
        logic sBig, sSml;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
        mb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
        ovf = 1'b0;
        if (ea == 31) begin
            r = {a[15], 5'h1F, 10'h000};
            ovf = 1'b1;
            return;
        end
        if (eb == 31) begin
            r = {b[15], 5'h1F, 10'h000};
            ovf = 1'b1;
            return;
        end
        if (ea > eb || (ea == eb && ma >= mb)) begin
            eBig = ea; mBig = ma; sBig = a[15]; eSml = eb; mSml = mb; sSml = b[15];
        end else begin
            eBig = eb; mBig = mb; sBig = b[15]; eSml = ea; mSml = ma; sSml = a[15];
        end
        d = eBig - eSml;
        if (d >= 12) mSml = 0;
        else mSml = mSml >> d;
        s = (sBig == sSml) ? mBig + mSml : mBig - mSml;
        if (s == 0) begin
            r = 16'h0000;
            return;
        end
        e = eBig;
        while (s >= 2048) begin
            s = s >> 1;
            e++;
        end
        while (s < 1024) begin
            s = s << 1;
            e--;
        end
        if (e >= 31) begin
            r = {sBig, 5'h1F, 10'h000};
            ovf = 1'b1;
        end else if (e <= 0) begin
            r = 16'h0000;
        end else begin
            r = {sBig, 5'(e), 10'(s)};
        end
    endfunction

    function automatic logic [15:0] randomFp();
        int sel;
        logic [4:0] e;
        logic [9:0] m;
        logic s;
        sel = $urandom_range(0, 63);
        m = 10'($urandom);
        s = 1'($urandom);
        if (sel == 0) e = 5'h1F;
        else if (sel < 4) e = 5'h00;
        else if (sel < 8) e = 5'($urandom_range(28, 30));
        else e = 5'($urandom_range(12, 18));
        return {s, e, m};
    endfunction

    // Present one beat and wait for the edge that accepts it
    task automatic applyStimulus(input logic [15:0] d, input logic e, input logic l,
                                 input logic md);
        int waitCycles;
        waitCycles = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_error = e;
        in_last  = l;
        mode     = md;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_error = 1'b0;
    endtask

    // Check the held result, optionally stall, then take it
    task automatic collectResult(input logic [31:0] expData, input logic expErr,
                                 input int expCnt);
        int stall;
        checkOutput("latency", 32'(out_valid), 32'd1);
        stall = $urandom_range(0, 3);
        repeat (stall) begin
            @(negedge clk);
            checkOutput("holdInReady", 32'(in_ready), 32'd0);
        end
        checkOutput("outData", 32'(out_data), expData);
        checkOutput("outError", 32'(out_error), 32'(expErr));
        checkOutput("outCount", 32'(out_count), 32'(expCnt));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("validDrop", 32'(out_valid), 32'd0);
        checkOutput("inReadyBack", 32'(in_ready), 32'd1);
    endtask

    // Run the group held in beatQ/errQ; later beats drive the opposite mode pin
    task automatic runGroup(input logic md, input bit gaps, input bit useExp,
                            input logic [31:0] expDataIn, input logic expErrIn,
                            input int expCntIn);
        longint accInt;
        logic [15:0] accFp, r;
        logic o, err;
        int cnt, n;
        logic [31:0] expData;
        n = beatQ.size();
        accInt = 0;
        accFp = 16'h0000;
        err = 1'b0;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (cnt < CNT_MAX) cnt++;
            err |= errQ[i];
            if (md) begin
                fpAddRef(accFp, beatQ[i], r, o);
                accFp = r;
                err |= o;
            end else begin
                accInt = accInt + longint'($signed(beatQ[i]));
                if (accInt > INT_MAX) begin
                    accInt = INT_MAX;
                    err = 1'b1;
                end else if (accInt < INT_MIN) begin
                    accInt = INT_MIN;
                    err = 1'b1;
                end
            end
        end
        expData = md ? {16'h0000, accFp} : (32'(accInt) & ((32'd1 << ACC_W) - 1));
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_error = 1'b1;
                in_data  = 16'($urandom);
                mode     = 1'($urandom);
                @(negedge clk);
            end
            applyStimulus(beatQ[i], errQ[i], (i == n - 1), (i == 0) ? md : ~md);
        end
        if (useExp) collectResult(expDataIn, expErrIn, expCntIn);
        else collectResult(expData, err, cnt);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        mode = 1'b0;
        in_valid = 1'b0;
        in_data = 16'h0000;
        in_error = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        checkOutput("rstData", 32'(out_data), 32'd0);
        checkOutput("rstCount", 32'(out_count), 32'd0);
        checkOutput("rstError", 32'(out_error), 32'd0);

        beatQ = '{16'h0003, 16'hFFFB, 16'h0064}; errQ = '{1'b0, 1'b0, 1'b0};
        runGroup(1'b0, 1'b0, 1'b1, 32'h0000_0062, 1'b0, 3);

        beatQ = '{16'h3C00, 16'h4000}; errQ = '{1'b0, 1'b0};
        runGroup(1'b1, 1'b0, 1'b1, 32'h0000_4200, 1'b0, 2);

        beatQ = '{16'h4000, 16'hC000}; errQ = '{1'b0, 1'b0};
        runGroup(1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 2);

        beatQ = '{16'h7BFF, 16'h7BFF}; errQ = '{1'b0, 1'b0};
        runGroup(1'b1, 1'b0, 1'b1, 32'h0000_7C00, 1'b1, 2);

        beatQ = '{16'h7FFF, 16'h7FFF, 16'h7FFF}; errQ = '{1'b0, 1'b0, 1'b0};
        runGroup(1'b0, 1'b0, 1'b1, 32'h0000_FFFF, 1'b1, 3);

        beatQ = '{16'h0001, 16'h0002, 16'h0003}; errQ = '{1'b0, 1'b1, 1'b0};
        runGroup(1'b0, 1'b0, 1'b1, 32'h0000_0006, 1'b1, 3);

        // Mode pin flips to 0 on the second beat; the group stays fp
        beatQ = '{16'h3C00, 16'h3C00}; errQ = '{1'b0, 1'b0};
        runGroup(1'b1, 1'b0, 1'b1, 32'h0000_4000, 1'b0, 2);

        // Count saturates at 15
        beatQ.delete(); errQ.delete();
        for (int i = 0; i < 18; i++) begin
            beatQ.push_back(16'h0001);
            errQ.push_back(1'b0);
        end
        runGroup(1'b0, 1'b1, 1'b1, 32'd18, 1'b0, CNT_MAX);

        // Backpressure with a waiting beat
        applyStimulus(16'h0010, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h0020, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 16'h0007; in_last = 1'b1; in_error = 1'b0; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("bpInReady", 32'(in_ready), 32'd0);
            checkOutput("bpValid", 32'(out_valid), 32'd1);
            checkOutput("bpData", 32'(out_data), 32'h30);
            checkOutput("bpCount", 32'(out_count), 32'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bpDrop", 32'(out_valid), 32'd0);
        checkOutput("bpReady", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        collectResult(32'h7, 1'b0, 1);

        // Asynchronous reset mid-group
        applyStimulus(16'h0001, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h0002, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", 32'(out_valid), 32'd0);
        checkOutput("midRstCount", 32'(out_count), 32'd0);
        checkOutput("midRstData", 32'(out_data), 32'd0);
        checkOutput("midRstError", 32'(out_error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        beatQ = '{16'h0005}; errQ = '{1'b0};
        runGroup(1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1);

        // Random groups against the model
        for (int g = 0; g < 40; g++) begin
            logic md;
            int n;
            md = 1'($urandom);
            n = $urandom_range(1, 20);
            beatQ.delete(); errQ.delete();
            for (int i = 0; i < n; i++) begin
                beatQ.push_back(md ? randomFp() : 16'($urandom));
                errQ.push_back($urandom_range(0, 9) == 0);
            end
            runGroup(md, 1'b1, 1'b0, 32'd0, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Downstream partial-sum stage for each processing element of the systolic array. It consumes the 16-bit product stream from the PE multiplier, either int8 products in two's complement or fp16 products. It accumulates one dot-product group, delimited by `in_last`, into a single result and presents that result on a valid/ready output toward the array drain. Mode is latched per group, errors are sticky per group, and backpressure stalls the multiplier side.

## Interface
Parameters:
- `ACC_W`, default 32: int-mode accumulator width in bits. Must be ≥17.
- `CNT_W`, default 8: width of the beat counter.

Ports:
- `clk`  in  1  the single clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `mode`  in  1  1 = fp16, 0 = int. Sampled on the first beat of each group.
- `in_valid`  in  1  a product beat is present.
- `in_ready`  out  1  the block can accept a beat.
- `in_data`  in  16  the product: int16 two's complement, or fp16.
- `in_error`  in  1  the multiplier's fp overflow/underflow flag for this beat.
- `in_last`  in  1  marks the final beat of the group.
- `out_valid`  out  1  a group result is held.
- `out_ready`  in  1  the downstream side accepts the result.
- `out_data`  out  ACC_W  int mode: signed sum. fp mode: `{zeros, fp16 sum}`.
- `out_error`  out  1  sticky error for the group.
- `out_count`  out  CNT_W  number of beats in the group, saturating.

## Operation
- **Handshakes.** A beat is accepted when `in_valid && in_ready`. The result transfers when `out_valid && out_ready`.
- **State `IDLE`.** The accumulator is zero, the count is 0 and the error flag is 0.
  - An accepted beat latches `mode`.
  - It sets acc = 0 + beat.
  - Without `in_last`, go to `ACCUM`. With `in_last`, go to `HOLD`.
- **State `ACCUM`.** Each accepted beat sets acc = acc + beat.
  - The `mode` input is ignored here; the latched mode is used.
  - A beat with `in_last` moves the block to `HOLD`.
- **State `HOLD`.**
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_data`, `out_error` and `out_count` are stable.
  - On transfer, the accumulator, count and error are cleared and the block returns to `IDLE`.
  - `in_ready` stays 0 during the transfer cycle; there is no same-cycle bypass.
- **`in_ready`.** Equals `(state != HOLD)`. It is registered-state based and never depends on `in_valid` combinationally.
- **Count.** Increments on every accepted beat and saturates at 2^CNT_W−1.
- **Error flag.** OR of `in_error` over every accepted beat, plus any internal overflow.
- **Int arithmetic.**
  - Sign-extend `in_data` to ACC_W and add with saturation to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - On saturation, clamp the accumulator and set the error flag.
- **fp16 arithmetic.** Single-cycle add.
  - exp = 0 is treated as ±0; subnormals are flushed.
  - exp = 31 is treated as ±inf and sets the error flag; the result is inf with the sign of the first inf seen.
  - The smaller operand is aligned by a right shift of the exponent difference, with truncation; shifts ≥ 12 yield 0.
  - Magnitudes are added or subtracted, then the result is normalised with a leading-one shift.
  - Rounding is toward zero (truncate).
  - An exact cancellation gives +0 (0x0000).
  - A normalised exponent ≥ 31 gives `{sign,5'h1F,10'h0}` and sets the error flag.
  - A normalised exponent ≤ 0 gives +0 and does not set the error flag.
- **Reset.** Asserting `rst` at any time, including mid-group or in `HOLD`, forces the following immediately:
  - state = `IDLE`;
  - `out_valid` = 0;
  - `out_data` = 0;
  - `out_error` = 0;
  - `out_count` = 0;
  - `in_ready` = 1 after release.
  - The partial group is discarded.

## Timing
- All state is updated on the rising edge of `clk`. `rst` acts asynchronously.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- Throughput: one beat per cycle inside a group. There is at least one bubble cycle per group, because the `HOLD` transfer cycle does not accept input.
- While `HOLD` is stalled (`out_ready` = 0), no input is accepted and outputs hold for an unbounded time.
- A beat with `in_valid` = 0 causes no change, even if `in_last` = 1.
- `in_error` and `in_last` are sampled only on accepted beats.

## Test plan
- **Int group.** Mode 0, beats 0x0003, 0xFFFB, 0x0064 (last) → one cycle later: `out_valid` = 1, `out_data` = 0x00000062, `out_count` = 3, `out_error` = 0.
- **fp16 group and cancellation.**
  - Mode 1, beats 0x3C00, 0x4000 (last) → `out_data[15:0]` = 0x4200, `out_error` = 0.
  - Next group 0x4000, 0xC000 (last) → 0x0000.
- **Overflow and sticky error.**
  - fp beats 0x7BFF, 0x7BFF (last) → 0x7C00, `out_error` = 1.
  - With ACC_W = 17, int beats 0x7FFF ×3 (last on the third) → `out_data` = 17'h0FFFF, `out_error` = 1.
  - Separately, an `in_error` = 1 on a middle beat → `out_error` = 1 with the sum unaffected.
- **Backpressure.**
  - Hold `out_ready` = 0 for 4 cycles while in `HOLD` with `in_valid` = 1 → `in_ready` = 0 and outputs constant.
  - Raise `out_ready` → transfer occurs; the next cycle `in_ready` = 1 and the waiting beat is accepted into a fresh group.
- **Mode latch.** Group starts with mode 1 and 0x3C00; `mode` is driven to 0 for the second beat 0x3C00 (last) → result 0x4000 (fp add).
- **Reset mid-group.**
  - Pulse `rst` after 2 of 4 beats → `out_valid` = 0 and counters are 0 immediately.
  - A following 1-beat group 0x0005 (last, mode 0) → `out_data` = 5, `out_count` = 1.
